inst_encoder: RTL
=================

Name: inst_encoder

Overview:
- Field-to-machine-word encoder for RV32I; the inverse of the instruction decoder.
- Accepts decoded fields (opcode, funct3, funct7, register numbers, 32-bit immediate) over a valid/ready stream and packs them into 32-bit instructions.
- Output is a sequential instruction-memory write stream with an auto-incrementing word address.
- Used by the boot/debug loader and by self-check benches to generate program images in hardware.

Parameters:
- ADDR_W, 10, width of the output word address.
- DEPTH, 1024, number of imem words; address wraps to 0 after DEPTH-1 (DEPTH <= 2**ADDR_W).
- ERRCNT_W, 8, width of the saturating error counter.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input field bundle valid
- in_ready  out  1  encoder can accept the bundle
- in_op  in  7  opcode using the shared opcode constants (OP, OPIMM, LOAD, STORE, BRANCH, LUI, AUIPC, JAL, JALR)
- in_funct3  in  3  funct3
- in_funct7  in  7  funct7 (OP, OPIMM shifts)
- in_rd  in  5  destination register
- in_rs1  in  5  source register 1
- in_rs2  in  5  source register 2
- in_imm  in  32  immediate value, in the same numeric form the decoder emits
- addr_load  in  1  load the address counter from addr_base
- addr_base  in  ADDR_W  start address
- out_valid  out  1  encoded word valid
- out_ready  in  1  imem writer accepts the word
- out_inst  out  32  encoded instruction
- out_addr  out  ADDR_W  word address for out_inst
- out_err  out  1  this word is a substituted NOP for an illegal bundle
- err_cnt  out  ERRCNT_W  saturating count of illegal bundles

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset values: out_valid=0, out_inst=0, out_addr=0, out_err=0, err_cnt=0, both pipe valids=0, address counter=0.
- Pipeline: two stages.
  - S1 registers the fields plus the legality result.
  - S2 registers the assembled word.
  - Latency is 2 cycles from input handshake to out_valid when not stalled.
  - Throughput is 1 word per cycle.
- Handshake:
  - Transfer occurs when valid&&ready. Valid is never dropped while ready=0.
  - in_ready = !s1_valid || s2_can_load, where s2_can_load = !out_valid || out_ready.
  - With out_ready=0, at most 2 bundles are held and in_ready deasserts.
- Formats:
  - R: OP.
  - I: OPIMM, LOAD, JALR. Shifts use {funct7, imm[4:0]}.
  - S: STORE.
  - B: BRANCH, imm[12:1].
  - U: LUI, AUIPC, imm[31:12].
  - J: JAL, imm[20:1].
- Legality (illegal when any of these fails):
  - I/S: imm[31:11] all equal.
  - Shift: imm[31:5]==0; funct7 is 0x00, or 0x20 only for SRAI/SRA/SUB.
  - B: imm[31:12] all equal and imm[0]==0.
  - J: imm[31:20] all equal and imm[0]==0.
  - U: imm[11:0]==0.
  - Opcode and funct3 must belong to the RV32I set (e.g. LOAD funct3 011 is illegal).
- Illegal bundle: out_inst=0x00000013 (NOP), out_err=1, err_cnt+1 saturating at all-ones. The bundle still consumes an address.
- Address:
  - out_addr takes the counter value when a word enters S2.
  - The counter increments on each S2 load and wraps DEPTH-1 to 0.
  - addr_load has priority over increment: the next S2 load uses addr_base. Words already in S2 keep their address.
  - addr_load and an S2 load in the same cycle: the loaded word gets addr_base, and the counter becomes addr_base+1.
- Reset mid-operation: all in-flight words are discarded, with no partial output.

Optional Feature:
- Macro INST_ENCODER_DROP_ILLEGAL_EN.
- Defined: illegal bundles are consumed (in_ready behaves normally), never reach S2, and consume no address. err_cnt still increments. out_err is tied 0.
- Undefined: NOP substitution as described in Behaviour.

Decomposition:
- Reuse the shared define header for opcode and funct constants. Add a new encoding constant NOP_INST=32'h00000013 there.
- One sub-module, inst_imm_pack: purely combinational. Takes op/funct3/funct7/imm and returns the packed immediate bit-fields plus imm_ok.

Test Plan:
- addi x1,x0,5 (OPIMM, f3=0, rd=1, rs1=0, imm=5) with addr_load base=0x010 -> after 2 cycles out_inst=0x00500093, out_addr=0x010, out_err=0.
- lui x5 imm=0x12345000 -> 0x123452B7. Then sw x2,8(x1) -> 0x0020A423 at out_addr+1.
- jal x1 imm=8 -> 0x008000EF. jal imm=6 (fine) and jal imm=3 (imm[0]=1) -> 0x00000013, out_err=1, err_cnt=1.
- addi imm=4096 repeated 300 times -> err_cnt saturates at 255. With the macro defined: no output words and the address is unchanged.
- out_ready=0 while streaming 3 bundles -> in_ready drops after 2 accepted. Words hold stable. Releasing out_ready yields 3 words in order with consecutive addresses.
- Base = DEPTH-1 with 2 words -> addresses 1023 then 0. Assert rst_n low with S1/S2 full -> out_valid=0 immediately and err_cnt=0.

Source files
------------

// File: rtl/inst_encoder_pkg.sv
// Shared RV32I opcode and encoding constants plus format classification helpers.
// Optional build macro: INST_ENCODER_DROP_ILLEGAL_EN (consumed by inst_encoder).
// Pure declarations, no logic.
package inst_encoder_pkg;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;

   localparam logic [6:0]  FUNCT7_ALT = 7'h20;
   localparam logic [31:0] NOP_INST   = 32'h00000013;

   typedef enum logic [2:0] {FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_X} fmt_e;

   // S1 contents: raw fields, pre-placed immediate bits and the legality verdict
   typedef struct packed {
      logic [6:0]  op;
      logic [2:0]  f3;
      logic [6:0]  f7;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [31:0] imm_bits;
      logic        legal;
   } s1_t;

   function automatic fmt_e op_fmt(input logic [6:0] op);
      case (op)
         OPC_OP:                        return FMT_R;
         OPC_OPIMM, OPC_LOAD, OPC_JALR: return FMT_I;
         OPC_STORE:                     return FMT_S;
         OPC_BRANCH:                    return FMT_B;
         OPC_LUI, OPC_AUIPC:            return FMT_U;
         OPC_JAL:                       return FMT_J;
         default:                       return FMT_X;
      endcase
   endfunction

   function automatic logic is_shift(input logic [6:0] op, input logic [2:0] f3);
      return (op == OPC_OPIMM) && (f3[1:0] == 2'b01);
   endfunction

   // Opcode/funct3 (and R-type funct7) membership in RV32I; immediates checked elsewhere
   function automatic logic opf3_ok(input logic [6:0] op, input logic [2:0] f3,
                                    input logic [6:0] f7);
      case (op)
         OPC_OP:     return (f7 == 7'h00) || ((f7 == FUNCT7_ALT) && (f3 == 3'b000 || f3 == 3'b101));
         OPC_OPIMM:  return 1'b1;
         OPC_LOAD:   return (f3 != 3'b011) && (f3 != 3'b110) && (f3 != 3'b111);
         OPC_STORE:  return (f3 <= 3'b010);
         OPC_BRANCH: return (f3 != 3'b010) && (f3 != 3'b011);
         OPC_JALR:   return (f3 == 3'b000);
         OPC_LUI, OPC_AUIPC, OPC_JAL: return 1'b1;
         default:    return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/inst_imm_pack.sv
// Places the immediate into its instruction bit positions for the opcode's format and flags range errors.
// Latency: combinational.
// Backpressure: none (no state).
module inst_imm_pack
   import inst_encoder_pkg::*;
(
   input  logic [6:0]  op,
   input  logic [2:0]  funct3,
   input  logic [6:0]  funct7,
   input  logic [31:0] imm,
   output logic [31:0] imm_bits,
   output logic        imm_ok
);

   logic i_sx, b_sx, j_sx;

   // Upper immediate bits must be pure sign extension of the encodable field
   assign i_sx = (imm[31:11] == '0) || (imm[31:11] == '1);
   assign b_sx = (imm[31:12] == '0) || (imm[31:12] == '1);
   assign j_sx = (imm[31:20] == '0) || (imm[31:20] == '1);

   // Scatter immediate bits per format; shifts carry funct7 in the upper I-field
   always_comb begin
      imm_bits = '0;
      imm_ok   = 1'b1;
      case (op_fmt(op))
         FMT_I: begin
            if (is_shift(op, funct3)) begin
               imm_bits[31:20] = {funct7, imm[4:0]};
               imm_ok = (imm[31:5] == '0) &&
                        ((funct7 == 7'h00) || ((funct7 == FUNCT7_ALT) && (funct3 == 3'b101)));
            end else begin
               imm_bits[31:20] = imm[11:0];
               imm_ok = i_sx;
            end
         end
         FMT_S: begin
            imm_bits[31:25] = imm[11:5];
            imm_bits[11:7]  = imm[4:0];
            imm_ok = i_sx;
         end
         FMT_B: begin
            imm_bits[31]    = imm[12];
            imm_bits[30:25] = imm[10:5];
            imm_bits[11:8]  = imm[4:1];
            imm_bits[7]     = imm[11];
            imm_ok = b_sx && !imm[0];
         end
         FMT_U: begin
            imm_bits[31:12] = imm[31:12];
            imm_ok = (imm[11:0] == '0);
         end
         FMT_J: begin
            imm_bits[31]    = imm[20];
            imm_bits[30:21] = imm[10:1];
            imm_bits[20]    = imm[11];
            imm_bits[19:12] = imm[19:12];
            imm_ok = j_sx && !imm[0];
         end
         default: begin
            imm_bits = '0;
            imm_ok   = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/inst_encoder.sv
// RV32I field-bundle to machine-word encoder feeding a sequential imem write stream (macro INST_ENCODER_DROP_ILLEGAL_EN drops illegal bundles instead of emitting NOPs).
// Latency: 2 cycles input handshake to out_valid; 1 word/cycle throughput.
// Backpressure: out_ready=0 fills S2 then S1 (2 bundles held), then in_ready drops.
module inst_encoder
   import inst_encoder_pkg::*;
#(
   parameter int ADDR_W   = 10,
   parameter int DEPTH    = 1024,
   parameter int ERRCNT_W = 8
)(
   input  logic                clk,
   input  logic                rst_n,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [6:0]          in_op,
   input  logic [2:0]          in_funct3,
   input  logic [6:0]          in_funct7,
   input  logic [4:0]          in_rd,
   input  logic [4:0]          in_rs1,
   input  logic [4:0]          in_rs2,
   input  logic [31:0]         in_imm,
   input  logic                addr_load,
   input  logic [ADDR_W-1:0]   addr_base,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [31:0]         out_inst,
   output logic [ADDR_W-1:0]   out_addr,
   output logic                out_err,
   output logic [ERRCNT_W-1:0] err_cnt
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

   s1_t                 s1_q, s1_d;
   logic                s1_valid_q, s1_valid_d;
   logic                out_valid_q, out_valid_d;
   logic [31:0]         out_inst_q, out_inst_d;
   logic [ADDR_W-1:0]   out_addr_q, out_addr_d;
   logic                out_err_q, out_err_d;
   logic [ERRCNT_W-1:0] err_cnt_q, err_cnt_d;
   logic [ADDR_W-1:0]   cnt_q, cnt_d;

   logic [31:0]         imm_bits_in;
   logic                imm_ok_in;
   logic                s2_can_load, s1_adv, s2_load;
   logic [31:0]         word;
   logic [ADDR_W-1:0]   addr_src;
   fmt_e                fmt;

   inst_imm_pack u_imm_pack (
      .op       (in_op),
      .funct3   (in_funct3),
      .funct7   (in_funct7),
      .imm      (in_imm),
      .imm_bits (imm_bits_in),
      .imm_ok   (imm_ok_in)
   );

   assign s2_can_load = !out_valid_q || out_ready;
   assign in_ready    = !s1_valid_q || s2_can_load;
   assign s1_adv      = s1_valid_q && s2_can_load;
`ifdef INST_ENCODER_DROP_ILLEGAL_EN
   assign s2_load     = s1_adv && s1_q.legal;
`else
   assign s2_load     = s1_adv;
`endif

   // Assemble the machine word from S1 fields; illegal bundles become a NOP
   always_comb begin
      fmt  = op_fmt(s1_q.op);
      word = s1_q.imm_bits;
      word[6:0] = s1_q.op;
      if (fmt == FMT_R || fmt == FMT_I || fmt == FMT_U || fmt == FMT_J) word[11:7] = s1_q.rd;
      if (fmt == FMT_R || fmt == FMT_I || fmt == FMT_S || fmt == FMT_B) begin
         word[14:12] = s1_q.f3;
         word[19:15] = s1_q.rs1;
      end
      if (fmt == FMT_R || fmt == FMT_S || fmt == FMT_B) word[24:20] = s1_q.rs2;
      if (fmt == FMT_R) word[31:25] = s1_q.f7;
      if (!s1_q.legal) word = NOP_INST;
   end

   // Next-state for both pipe stages, the address counter and the error counter
   always_comb begin
      s1_d        = s1_q;
      s1_valid_d  = s1_valid_q;
      out_valid_d = out_valid_q;
      out_inst_d  = out_inst_q;
      out_addr_d  = out_addr_q;
      out_err_d   = out_err_q;
      err_cnt_d   = err_cnt_q;
      cnt_d       = cnt_q;
      addr_src    = addr_load ? addr_base : cnt_q;

      if (in_ready) begin
         s1_valid_d = in_valid;
         if (in_valid) begin
            s1_d.op       = in_op;
            s1_d.f3       = in_funct3;
            s1_d.f7       = in_funct7;
            s1_d.rd       = in_rd;
            s1_d.rs1      = in_rs1;
            s1_d.rs2      = in_rs2;
            s1_d.imm_bits = imm_bits_in;
            s1_d.legal    = imm_ok_in && opf3_ok(in_op, in_funct3, in_funct7);
         end
      end

      if (s2_can_load) out_valid_d = s2_load;

      if (s2_load) begin
         out_inst_d = word;
         out_addr_d = addr_src;
         cnt_d      = (addr_src == LAST_ADDR) ? '0 : addr_src + 1'b1;
`ifdef INST_ENCODER_DROP_ILLEGAL_EN
         out_err_d  = 1'b0;
`else
         out_err_d  = !s1_q.legal;
`endif
      end else if (addr_load) begin
         cnt_d = addr_base;
      end

      if (s1_adv && !s1_q.legal && (err_cnt_q != {ERRCNT_W{1'b1}}))
         err_cnt_d = err_cnt_q + 1'b1;
   end

   // State registers; reset discards everything in flight
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_q        <= '0;
         s1_valid_q  <= 1'b0;
         out_valid_q <= 1'b0;
         out_inst_q  <= '0;
         out_addr_q  <= '0;
         out_err_q   <= 1'b0;
         err_cnt_q   <= '0;
         cnt_q       <= '0;
      end else begin
         s1_q        <= s1_d;
         s1_valid_q  <= s1_valid_d;
         out_valid_q <= out_valid_d;
         out_inst_q  <= out_inst_d;
         out_addr_q  <= out_addr_d;
         out_err_q   <= out_err_d;
         err_cnt_q   <= err_cnt_d;
         cnt_q       <= cnt_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_inst  = out_inst_q;
   assign out_addr  = out_addr_q;
   assign out_err   = out_err_q;
   assign err_cnt   = err_cnt_q;

endmodule
